data_mem_clr: RTL and testbench
===============================

# data_mem_clr

Parametrised single-port data memory with a registered read path, write-first read-during-write forwarding, and a hardware clear engine. After reset or on request, the clear engine fills every word with a constant before the memory accepts accesses. It replaces the fixed 8-bit combinational-read data memory in the processor datapath and sits between the load/store unit and the register file writeback.

## Interface

**Parameters**
- `AW`, 8, address width; depth is 2**AW words.
- `DW`, 8, data word width in bits.
- `CLR_VAL`, 0, DW-bit value written to every word during a clear.

**Ports**
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `DataAddress`  in  AW  word address for read and write.
- `ReadMem`  in  1  read request.
- `WriteMem`  in  1  write request.
- `DataIn`  in  DW  write data.
- `ClearReq`  in  1  single-cycle pulse; restarts the clear engine.
- `DataOut`  out  DW  registered read data; holds its value between reads.
- `ReadValid`  out  1  one-cycle pulse; `DataOut` was updated this cycle.
- `Busy`  out  1  high while the clear engine runs; requests are dropped.
- `RdCount`  out  16  accepted-read counter (see Configuration).
- `WrCount`  out  16  accepted-write counter (see Configuration).

## Operation

**FSM**
- Two states: CLEAR and READY.
- Reset forces CLEAR and `clr_ptr` = 0.

**CLEAR state**
- Each rising edge writes `CLR_VAL` to `mem[clr_ptr]`, then increments `clr_ptr`.
- The edge that writes word 2**AW−1 moves the FSM to READY.
- `Busy` = (state == CLEAR).
- `ReadMem`, `WriteMem` and `ClearReq` are ignored. The array is not written by `DataIn`, `ReadValid` stays 0, and `DataOut` holds.

**READY state**
- Accepted write: `WriteMem`=1 → `mem[DataAddress]` ← `DataIn` at the edge.
- Accepted read: `ReadMem`=1 → `DataOut` ← `mem[DataAddress]` at the edge, and `ReadValid`=1 for the following cycle.
- Read and write in the same cycle: both are accepted. The read returns `DataIn` (write-first), not the old contents.
- `ClearReq`=1 in READY: moves to CLEAR with `clr_ptr`=0 at that edge. Any `ReadMem`/`WriteMem` in the same cycle is dropped, and counters clear.

**Width rules**
- `clr_ptr` is AW+1 bits so the terminal condition is explicit; the count never wraps.
- Counters are 16-bit saturating at 0xFFFF and never wrap.

## Timing

**Reset values** (applied asynchronously)
- `DataOut` = 0, `ReadValid` = 0, `Busy` = 1, `RdCount` = 0, `WrCount` = 0.
- Array contents are undefined until the clear completes.

**Clear duration**
- Exactly 2**AW cycles.
- The first rising edge after `reset` falls writes word 0.
- Edge k writes word k−1.
- `Busy` falls after edge 2**AW.
- The first request that can be accepted is sampled at edge 2**AW+1.

**Read latency**
- One cycle: request sampled at edge n, data and `ReadValid` visible after edge n.
- Back-to-back reads sustain one per cycle.

**Write latency**
- The word is updated at the sampling edge.
- A read of the same address in the next cycle returns the new value.

**Reset during a clear** restarts from word 0 with a full 2**AW-cycle clear. Partially cleared contents are not trusted.

**`ClearReq` while already in CLEAR** has no effect and does not restart the clear.

## Configuration

`DMEM_STATS_EN`
- **Defined:** `RdCount` increments on each accepted read and `WrCount` on each accepted write. A simultaneous read and write increments both. Both saturate at 0xFFFF and clear on reset or an accepted `ClearReq`.
- **Undefined:** counter logic is not built, and `RdCount`/`WrCount` are tied to 0. The ports exist in both builds.

## Test plan

All scenarios use AW=4, DW=8, CLR_VAL=0x00 unless stated.

1. **Reset and clear.** Assert `reset` 2 cycles, release → `Busy`=1 for exactly 16 cycles, then 0. Reading addresses 0–15 afterwards returns 0x00 each, with `ReadValid` pulsing once per read.
2. **Write then read.** Write 0xA5 to addr 3, then read addr 3 next cycle → `DataOut`=0xA5 and `ReadValid`=1 one cycle after the read request. Then drop `ReadMem` → `DataOut` holds 0xA5 and `ReadValid`=0.
3. **Read-during-write.** Same cycle: `ReadMem`=`WriteMem`=1, addr 5, `DataIn`=0x3C, old contents 0x11 → `DataOut`=0x3C.
4. **Requests during a clear.** Pulse `ClearReq` with `WriteMem`=1, addr 3, `DataIn`=0xFF in the same cycle → write dropped, `Busy` high for 16 cycles. Also assert `ReadMem` during CLEAR → no `ReadValid`. Read addr 3 after the clear → 0x00.
5. **Reset mid-clear.** Assert `reset` when `clr_ptr`=7 → on release `Busy` stays high for a full 16 cycles. With CLR_VAL=0x5A, all 16 words read 0x5A afterwards.
6. **Counters (`DMEM_STATS_EN` defined).** 3 reads, 2 writes and 1 combined read+write → `RdCount`=4, `WrCount`=3. Force the counter to 0xFFFE and issue 3 reads → `RdCount`=0xFFFF. With the macro undefined, both counters read 0 throughout.

Source files
------------

// File: rtl/data_mem_clr_if.sv
// Bus interface for data_mem_clr: load/store requests, clear request,
// read response, busy flag and access statistics.
interface data_mem_clr_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic [AW-1:0] DataAddress;
    logic          ReadMem;
    logic          WriteMem;
    logic [DW-1:0] DataIn;
    logic          ClearReq;
    logic [DW-1:0] DataOut;
    logic          ReadValid;
    logic          Busy;
    logic [15:0]   RdCount;
    logic [15:0]   WrCount;

    // Requester side (load/store unit)
    modport master (
        output DataAddress, ReadMem, WriteMem, DataIn, ClearReq,
        input  DataOut, ReadValid, Busy, RdCount, WrCount
    );

    // Memory side
    modport slave (
        input  DataAddress, ReadMem, WriteMem, DataIn, ClearReq,
        output DataOut, ReadValid, Busy, RdCount, WrCount
    );
endinterface

// File: rtl/data_mem_clr.sv
// Single-port data memory with registered read, write-first forwarding on
// read-during-write, and a clear engine that fills every word with CLR_VAL
// after reset or on ClearReq before any access is accepted.
// Optional feature macro: DMEM_STATS_EN (saturating read/write counters);
// without it RdCount/WrCount are tied to zero.
module data_mem_clr #(
    parameter int            AW      = 8,
    parameter int            DW      = 8,
    parameter logic [DW-1:0] CLR_VAL = '0
) (
    input  logic           clk,
    input  logic           reset,
    data_mem_clr_if.slave  bus
);
    localparam int            DEPTH    = 2 ** AW;
    localparam logic [AW:0]   LAST_PTR = (AW + 1)'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t        state_reg;
    logic [AW:0]   clr_ptr_reg;

    logic [DW-1:0] mem [DEPTH];

    logic [DW-1:0] data_out_reg;
    logic          read_valid_reg;

    logic          ready;
    logic          clr_acc;
    logic          rd_acc;
    logic          wr_acc;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    // A clear request in READY wins over any access in the same cycle.
    assign ready   = (state_reg == READY);
    assign clr_acc = ready & bus.ClearReq;
    assign rd_acc  = ready & bus.ReadMem  & ~bus.ClearReq;
    assign wr_acc  = ready & bus.WriteMem & ~bus.ClearReq;

    // Single write port shared by the clear engine and the requester.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.DataAddress;
        mem_wdata = bus.DataIn;
        if (state_reg == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_ptr_reg[AW-1:0];
            mem_wdata = CLR_VAL;
        end else if (wr_acc) begin
            mem_we    = 1'b1;
        end
    end

    // Clear engine FSM: walk every word once, then serve accesses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= CLEAR;
            clr_ptr_reg <= '0;
        end else begin
            case (state_reg)
                CLEAR: begin
                    clr_ptr_reg <= clr_ptr_reg + 1'b1;
                    if (clr_ptr_reg == LAST_PTR) begin
                        state_reg <= READY;
                    end
                end
                READY: begin
                    if (bus.ClearReq) begin
                        state_reg   <= CLEAR;
                        clr_ptr_reg <= '0;
                    end
                end
                default: begin
                    state_reg   <= CLEAR;
                    clr_ptr_reg <= '0;
                end
            endcase
        end
    end

    // Memory array write; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Registered read with write-first forwarding; DataOut holds between reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_reg   <= '0;
            read_valid_reg <= 1'b0;
        end else begin
            read_valid_reg <= rd_acc;
            if (rd_acc) begin
                data_out_reg <= wr_acc ? bus.DataIn : mem[bus.DataAddress];
            end
        end
    end

    assign bus.DataOut   = data_out_reg;
    assign bus.ReadValid = read_valid_reg;
    assign bus.Busy      = (state_reg == CLEAR);

`ifdef DMEM_STATS_EN
    logic [15:0] rd_count_reg;
    logic [15:0] wr_count_reg;

    // Saturating access counters, cleared together with the memory.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_count_reg <= '0;
            wr_count_reg <= '0;
        end else if (clr_acc) begin
            rd_count_reg <= '0;
            wr_count_reg <= '0;
        end else begin
            if (rd_acc && (rd_count_reg != 16'hFFFF)) begin
                rd_count_reg <= rd_count_reg + 16'd1;
            end
            if (wr_acc && (wr_count_reg != 16'hFFFF)) begin
                wr_count_reg <= wr_count_reg + 16'd1;
            end
        end
    end

    assign bus.RdCount = rd_count_reg;
    assign bus.WrCount = wr_count_reg;
`else
    assign bus.RdCount = '0;
    assign bus.WrCount = '0;
`endif

endmodule

// File: tb/tb_data_mem_clr.sv
// Directed testbench for data_mem_clr (AW=4, DW=8). A second instance with
// CLR_VAL=0x5A covers reset in the middle of a clear.
module tb_data_mem_clr;
`ifdef DMEM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic reset2;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    data_mem_clr_if #(.AW(4), .DW(8)) bus ();
    data_mem_clr_if #(.AW(4), .DW(8)) bus2 ();

    data_mem_clr #(.AW(4), .DW(8), .CLR_VAL(8'h00)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    data_mem_clr #(.AW(4), .DW(8), .CLR_VAL(8'h5A)) dut2 (
        .clk   (clk),
        .reset (reset2),
        .bus   (bus2.slave)
    );

    task automatic idle();
        bus.ReadMem  = 1'b0;
        bus.WriteMem = 1'b0;
        bus.ClearReq = 1'b0;
    endtask

    // Wait for the clear engine to finish, returning the number of cycles Busy was seen high.
    task automatic wait_busy(input bit second, output int n);
        n = 0;
        while ((second ? bus2.Busy : bus.Busy) && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1;
        idle();
        bus.DataAddress = '0;
        bus.DataIn      = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.DataOut !== 8'h00 || bus.ReadValid !== 1'b0 || bus.Busy !== 1'b1 ||
            bus.RdCount !== 16'h0 || bus.WrCount !== 16'h0) begin
            errors++;
            $display("FAIL reset_values: DataOut=%h ReadValid=%b Busy=%b RdCount=%h WrCount=%h expected 00 0 1 0000 0000",
                     bus.DataOut, bus.ReadValid, bus.Busy, bus.RdCount, bus.WrCount);
        end
        reset = 1'b0;
        wait_busy(1'b0, n);
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL clear_duration: busy cycles=%0d expected 16", n);
        end
        $display("reset: clear took %0d cycles", n);
        // back-to-back reads of all words
        for (int a = 0; a < 16; a++) begin
            bus.ReadMem     = 1'b1;
            bus.DataAddress = 4'(a);
            @(negedge clk);
            checks++;
            if (bus.DataOut !== 8'h00 || bus.ReadValid !== 1'b1) begin
                errors++;
                $display("FAIL clear_read addr=%0d: DataOut=%h ReadValid=%b expected 00 1", a, bus.DataOut, bus.ReadValid);
            end
            $display("read addr=%0d data=%h valid=%b", a, bus.DataOut, bus.ReadValid);
        end
        idle();
        @(negedge clk);
        checks++;
        if (bus.ReadValid !== 1'b0) begin
            errors++;
            $display("FAIL valid_drop: ReadValid=%b expected 0", bus.ReadValid);
        end
    endtask

    task automatic test_write_read();
        bus.WriteMem    = 1'b1;
        bus.DataAddress = 4'd3;
        bus.DataIn      = 8'hA5;
        @(negedge clk);
        bus.WriteMem = 1'b0;
        bus.ReadMem  = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.DataOut !== 8'hA5 || bus.ReadValid !== 1'b1) begin
            errors++;
            $display("FAIL write_read: DataOut=%h ReadValid=%b expected a5 1", bus.DataOut, bus.ReadValid);
        end
        $display("write addr=3 a5, read back %h valid=%b", bus.DataOut, bus.ReadValid);
        idle();
        bus.DataAddress = 4'd0;
        @(negedge clk);
        checks++;
        if (bus.DataOut !== 8'hA5 || bus.ReadValid !== 1'b0) begin
            errors++;
            $display("FAIL read_hold: DataOut=%h ReadValid=%b expected a5 0", bus.DataOut, bus.ReadValid);
        end
    endtask

    task automatic test_read_during_write();
        bus.WriteMem    = 1'b1;
        bus.DataAddress = 4'd5;
        bus.DataIn      = 8'h11;
        @(negedge clk);
        bus.ReadMem  = 1'b1;
        bus.DataIn   = 8'h3C;
        @(negedge clk);
        checks++;
        if (bus.DataOut !== 8'h3C || bus.ReadValid !== 1'b1) begin
            errors++;
            $display("FAIL rdw_forward: DataOut=%h ReadValid=%b expected 3c 1", bus.DataOut, bus.ReadValid);
        end
        $display("read+write addr=5 data=%h", bus.DataOut);
        bus.WriteMem = 1'b0;
        bus.DataIn   = 8'h00;
        @(negedge clk);
        checks++;
        if (bus.DataOut !== 8'h3C) begin
            errors++;
            $display("FAIL rdw_stored: DataOut=%h expected 3c", bus.DataOut);
        end
        idle();
        @(negedge clk);
    endtask

    task automatic test_clear_requests();
        int n;
        bit rv_seen;
        bus.ClearReq    = 1'b1;
        bus.WriteMem    = 1'b1;
        bus.DataAddress = 4'd3;
        bus.DataIn      = 8'hFF;
        @(negedge clk);
        bus.ClearReq = 1'b0;
        bus.WriteMem = 1'b0;
        bus.ReadMem  = 1'b1;
        rv_seen = 1'b0;
        n = 0;
        while (bus.Busy && n < 40) begin
            if (bus.ReadValid) rv_seen = 1'b1;
            // a second ClearReq mid-clear must not restart it
            bus.ClearReq = (n == 5);
            @(negedge clk);
            n++;
        end
        idle();
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL clearreq_duration: busy cycles=%0d expected 16", n);
        end
        checks++;
        if (rv_seen !== 1'b0) begin
            errors++;
            $display("FAIL read_in_clear: ReadValid seen=%b expected 0", rv_seen);
        end
        checks++;
        if (bus.DataOut !== 8'h3C) begin
            errors++;
            $display("FAIL hold_in_clear: DataOut=%h expected 3c", bus.DataOut);
        end
        $display("clear request: busy %0d cycles", n);
        bus.ReadMem = 1'b1;
        @(negedge clk);
        idle();
        checks++;
        if (bus.DataOut !== 8'h00 || bus.ReadValid !== 1'b1) begin
            errors++;
            $display("FAIL dropped_write: DataOut=%h ReadValid=%b expected 00 1", bus.DataOut, bus.ReadValid);
        end
        $display("read addr=3 after clear data=%h", bus.DataOut);
    endtask

    task automatic test_reset_mid_clear();
        int n;
        reset2 = 1'b0;
        repeat (7) @(negedge clk);
        reset2 = 1'b1;
        @(negedge clk);
        checks++;
        if (bus2.Busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_busy: Busy=%b expected 1", bus2.Busy);
        end
        reset2 = 1'b0;
        wait_busy(1'b1, n);
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL mid_reset_duration: busy cycles=%0d expected 16", n);
        end
        $display("reset mid-clear: clear took %0d cycles", n);
        for (int a = 0; a < 16; a++) begin
            bus2.ReadMem     = 1'b1;
            bus2.DataAddress = 4'(a);
            @(negedge clk);
            checks++;
            if (bus2.DataOut !== 8'h5A || bus2.ReadValid !== 1'b1) begin
                errors++;
                $display("FAIL clr5a_read addr=%0d: DataOut=%h ReadValid=%b expected 5a 1", a, bus2.DataOut, bus2.ReadValid);
            end
        end
        bus2.ReadMem = 1'b0;
    endtask

    task automatic test_counters();
        int n;
        logic [15:0] exp_rd;
        logic [15:0] exp_wr;
        bus.ClearReq = 1'b1;
        @(negedge clk);
        idle();
        wait_busy(1'b0, n);
        checks++;
        if (n !== 16 || bus.RdCount !== 16'h0 || bus.WrCount !== 16'h0) begin
            errors++;
            $display("FAIL count_clear: busy=%0d RdCount=%h WrCount=%h expected 16 0000 0000", n, bus.RdCount, bus.WrCount);
        end
        for (int a = 0; a < 3; a++) begin
            bus.ReadMem     = 1'b1;
            bus.DataAddress = 4'(a);
            @(negedge clk);
        end
        bus.ReadMem = 1'b0;
        for (int a = 7; a < 9; a++) begin
            bus.WriteMem    = 1'b1;
            bus.DataAddress = 4'(a);
            bus.DataIn      = 8'(a);
            @(negedge clk);
        end
        bus.ReadMem     = 1'b1;
        bus.DataAddress = 4'd9;
        bus.DataIn      = 8'h99;
        @(negedge clk);
        idle();
        @(negedge clk);
        exp_rd = STATS ? 16'd4 : 16'd0;
        exp_wr = STATS ? 16'd3 : 16'd0;
        checks++;
        if (bus.RdCount !== exp_rd || bus.WrCount !== exp_wr) begin
            errors++;
            $display("FAIL counts: RdCount=%h WrCount=%h expected %h %h", bus.RdCount, bus.WrCount, exp_rd, exp_wr);
        end
        $display("counters: rd=%0d wr=%0d", bus.RdCount, bus.WrCount);
`ifdef DMEM_STATS_EN
        force dut.rd_count_reg = 16'hFFFE;
        #1;
        release dut.rd_count_reg;
`endif
        @(negedge clk);
        for (int a = 0; a < 3; a++) begin
            bus.ReadMem     = 1'b1;
            bus.DataAddress = 4'(a);
            @(negedge clk);
        end
        idle();
        @(negedge clk);
        exp_rd = STATS ? 16'hFFFF : 16'd0;
        checks++;
        if (bus.RdCount !== exp_rd || bus.WrCount !== exp_wr) begin
            errors++;
            $display("FAIL count_saturate: RdCount=%h WrCount=%h expected %h %h", bus.RdCount, bus.WrCount, exp_rd, exp_wr);
        end
        $display("saturation: rd=%h", bus.RdCount);
    endtask

    initial begin
        reset  = 1'b1;
        reset2 = 1'b1;
        bus2.ReadMem     = 1'b0;
        bus2.WriteMem    = 1'b0;
        bus2.ClearReq    = 1'b0;
        bus2.DataAddress = '0;
        bus2.DataIn      = '0;
        test_reset();
        test_write_read();
        test_read_during_write();
        test_clear_requests();
        test_reset_mid_clear();
        test_counters();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
